// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t                 : sequencer state encoding (also used for debug readback)
//   DEF_LOCK_STABLE_CYCLES  : default lock filter window for board tops
//   DEF_RESET_HOLD_CYCLES   : default core reset hold time for board tops
//   cnt_w()                 : counter width able to hold the value 'limit'
package pll_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_RESET_HOLD_CYCLES  = 16;

   function automatic int cnt_w(input int limit);
      return $clog2(limit) + 1;
   endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage to 0
//   d    : asynchronous input
//   q    : synchronized output (last stage), d appears after SYNC_STAGES edges
module cdc_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock indication into a clean core reset for clk_1x.
//   clk_1x, reset_1x : clock and synchronous active-high reset
//   pll_locked       : PLL lock, asynchronous
//   user_reset_req   : re-run the hold phase without re-filtering lock
//   status_clear     : clears lock_lost / lock_loss_count
//   core_reset       : registered reset to the core, low only in RUN
//   ready            : registered, high only in RUN
//   lock_lost        : sticky, set when lock drops while running
//   lock_loss_count  : saturating count of lock drops while running
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
   parameter int COUNT_WIDTH        = 8
) (
   input  logic                   clk_1x,
   input  logic                   reset_1x,
   input  logic                   pll_locked,
   input  logic                   user_reset_req,
   input  logic                   status_clear,
   output logic                   core_reset,
   output logic                   ready,
   output logic                   lock_lost,
   output logic [COUNT_WIDTH-1:0] lock_loss_count
);

   localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
   localparam int HW = cnt_w(RESET_HOLD_CYCLES);
   localparam logic [SW-1:0]          STABLE_MAX = SW'(LOCK_STABLE_CYCLES);
   localparam logic [HW-1:0]          HOLD_MAX   = HW'(RESET_HOLD_CYCLES);
   localparam logic [SW-1:0]          S_ONE      = SW'(1);
   localparam logic [HW-1:0]          H_ONE      = HW'(1);
   localparam logic [COUNT_WIDTH-1:0] C_ONE      = COUNT_WIDTH'(1);

   state_t           state;
   logic [SW-1:0]    stable_cnt;
   logic [HW-1:0]    hold_cnt;
   logic             locked_s;
   logic [COUNT_WIDTH-1:0] count_inc;

   cdc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk_1x),
      .rst (reset_1x),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // saturating increment; a coincident clear restarts the count at 1
   assign count_inc = status_clear                ? C_ONE :
                      (lock_loss_count == '1)     ? lock_loss_count :
                                                    lock_loss_count + C_ONE;

   // core_reset/ready only change on transitions into or out of RUN,
   // so they are written alongside the state change that causes them.
   always_ff @(posedge clk_1x) begin
      if (reset_1x) begin
         state           <= WAIT_LOCK;
         stable_cnt      <= '0;
         hold_cnt        <= '0;
         core_reset      <= 1'b1;
         ready           <= 1'b0;
         lock_lost       <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         if (status_clear) begin
            lock_lost       <= 1'b0;
            lock_loss_count <= '0;
         end
         case (state)
            WAIT_LOCK: begin
               stable_cnt <= '0;
               if (locked_s) begin
                  state      <= FILTER;
                  stable_cnt <= S_ONE;
               end
            end
            FILTER: begin
               if (!locked_s) begin
                  state      <= WAIT_LOCK;
                  stable_cnt <= '0;
               end else if (stable_cnt == STABLE_MAX) begin
                  state    <= HOLD;
                  hold_cnt <= H_ONE;
               end else begin
                  stable_cnt <= stable_cnt + S_ONE;
               end
            end
            HOLD: begin
               if (!locked_s) begin
                  state      <= WAIT_LOCK;
                  stable_cnt <= '0;
               end else if (user_reset_req) begin
                  hold_cnt <= H_ONE;
               end else if (hold_cnt == HOLD_MAX) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  ready      <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + H_ONE;
               end
            end
            RUN: begin
               // lock loss wins over a same-cycle user request
               if (!locked_s) begin
                  state           <= WAIT_LOCK;
                  stable_cnt      <= '0;
                  core_reset      <= 1'b1;
                  ready           <= 1'b0;
                  lock_lost       <= 1'b1;
                  lock_loss_count <= count_inc;
               end else if (user_reset_req) begin
                  state      <= HOLD;
                  hold_cnt   <= H_ONE;
                  core_reset <= 1'b1;
                  ready      <= 1'b0;
               end
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: two instances share stimulus, one with default
// parameters and one with a short filter window and a 2-bit loss counter.
module tb_pll_reset_sequencer;

   localparam int S  = 2;
   localparam int H  = 16;
   localparam int LA = 1024;
   localparam int LB = 8;
   localparam int HMAX = 16383;

   logic clk_1x = 1'b0;
   logic reset_1x, pll_locked, user_reset_req, status_clear;
   logic core_reset_a, ready_a, lock_lost_a;
   logic [7:0] cnt_a;
   logic core_reset_b, ready_b, lock_lost_b;
   logic [1:0] cnt_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // per-edge record of what the DUT sampled
   logic p_hist [0:HMAX];
   logic r_hist [0:HMAX];
   int   m_cnt_a = 0, m_cnt_b = 0;
   bit   m_lost_a = 0, m_lost_b = 0;

   always #5 clk_1x = ~clk_1x;

   pll_reset_sequencer dut_a (
      .clk_1x(clk_1x), .reset_1x(reset_1x), .pll_locked(pll_locked),
      .user_reset_req(user_reset_req), .status_clear(status_clear),
      .core_reset(core_reset_a), .ready(ready_a), .lock_lost(lock_lost_a),
      .lock_loss_count(cnt_a)
   );

   pll_reset_sequencer #(.LOCK_STABLE_CYCLES(LB), .COUNT_WIDTH(2)) dut_b (
      .clk_1x(clk_1x), .reset_1x(reset_1x), .pll_locked(pll_locked),
      .user_reset_req(user_reset_req), .status_clear(status_clear),
      .core_reset(core_reset_b), .ready(ready_b), .lock_lost(lock_lost_b),
      .lock_loss_count(cnt_b)
   );

   function automatic bit get_p(int k);
      if (k < 1 || k > HMAX) return 1'b0;
      return p_hist[k] === 1'b1;
   endfunction

   // Running after edge t means: no reset since the window began, and lock was
   // sampled high for every edge from t-S-L-H through t-S (filter + hold + the
   // edge that entered FILTER).
   function automatic bit exp_ready(int t, int L);
      if (t - S - L - H < 1 || t > HMAX) return 1'b0;
      for (int k = t - S - L - H; k <= t; k++) begin
         if (r_hist[k] !== 1'b0) return 1'b0;
         if (k <= t - S && !get_p(k)) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk_1x) begin
      cyc = cyc + 1;
      if (cyc <= HMAX) begin
         p_hist[cyc] = pll_locked;
         r_hist[cyc] = reset_1x;
      end
      if (reset_1x) begin
         m_cnt_a = 0; m_cnt_b = 0; m_lost_a = 0; m_lost_b = 0;
      end else begin
         if (status_clear) begin
            m_cnt_a = 0; m_cnt_b = 0; m_lost_a = 0; m_lost_b = 0;
         end
         if (exp_ready(cyc - 1, LA) && !get_p(cyc - S)) begin
            m_lost_a = 1;
            if (m_cnt_a < 255) m_cnt_a++;
         end
         if (exp_ready(cyc - 1, LB) && !get_p(cyc - S)) begin
            m_lost_b = 1;
            if (m_cnt_b < 3) m_cnt_b++;
         end
      end
   end

   task automatic test_reset;
      reset_1x = 1; pll_locked = 0; user_reset_req = 0; status_clear = 0;
      repeat (2) @(negedge clk_1x);
      total++; if (core_reset_a !== 1'b1) begin bad++; $display("FAIL rst_cr_a got=%b exp=1", core_reset_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL rst_ready_a got=%b exp=0", ready_a); end
      total++; if (lock_lost_a !== 1'b0) begin bad++; $display("FAIL rst_lost_a got=%b exp=0", lock_lost_a); end
      total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL rst_cnt_a got=%0d exp=0", cnt_a); end
      total++; if (core_reset_b !== 1'b1) begin bad++; $display("FAIL rst_cr_b got=%b exp=1", core_reset_b); end
      total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL rst_ready_b got=%b exp=0", ready_b); end
      total++; if (lock_lost_b !== 1'b0) begin bad++; $display("FAIL rst_lost_b got=%b exp=0", lock_lost_b); end
      total++; if (cnt_b !== 2'd0) begin bad++; $display("FAIL rst_cnt_b got=%0d exp=0", cnt_b); end
   endtask

   task automatic test_default_latency;
      int e0, fa = -1, fb = -1, ra = -1;
      reset_1x = 0; pll_locked = 1; e0 = cyc + 1;
      for (int n = 0; n < 1200 && fa < 0; n++) begin
         @(negedge clk_1x);
         if (fb < 0 && !core_reset_b) fb = cyc;
         if (ra < 0 && ready_a) ra = cyc;
         if (fa < 0 && !core_reset_a) fa = cyc;
      end
      total++; if (fa - e0 !== 1042) begin bad++; $display("FAIL lat_a got=%0d exp=1042", fa - e0); end
      total++; if (ra !== fa) begin bad++; $display("FAIL lat_ready_a got=%0d exp=%0d", ra, fa); end
      total++; if (fb - e0 !== 26) begin bad++; $display("FAIL lat_b got=%0d exp=26", fb - e0); end
      total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL lat_cnt_a got=%0d exp=0", cnt_a); end
   endtask

   task automatic test_lock_loss;
      int d, fa = -1;
      pll_locked = 0; d = cyc + 1;
      @(negedge clk_1x); pll_locked = 1;
      @(negedge clk_1x);
      total++; if (core_reset_a !== 1'b0) begin bad++; $display("FAIL loss_cr_early got=%b exp=0", core_reset_a); end
      @(negedge clk_1x);
      total++; if (core_reset_a !== 1'b1) begin bad++; $display("FAIL loss_cr got=%b exp=1", core_reset_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL loss_ready got=%b exp=0", ready_a); end
      total++; if (lock_lost_a !== 1'b1) begin bad++; $display("FAIL loss_lost_a got=%b exp=1", lock_lost_a); end
      total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL loss_cnt_a got=%0d exp=1", cnt_a); end
      total++; if (cnt_b !== 2'd1) begin bad++; $display("FAIL loss_cnt_b got=%0d exp=1", cnt_b); end
      for (int n = 0; n < 1200 && fa < 0; n++) begin
         @(negedge clk_1x);
         if (!core_reset_a) fa = cyc;
      end
      total++; if (fa - (d + 1) !== 1042) begin bad++; $display("FAIL relock_lat got=%0d exp=1042", fa - (d + 1)); end
   endtask

   task automatic test_glitch_filter;
      int e2, fb = -1;
      bit early = 0;
      pll_locked = 0; repeat (3) @(negedge clk_1x);
      status_clear = 1; @(negedge clk_1x); status_clear = 0;
      for (int i = 0; i < 6; i++) begin
         pll_locked = (i < 5);
         @(negedge clk_1x);
         if (!core_reset_b) early = 1;
      end
      pll_locked = 1; e2 = cyc + 1;
      for (int n = 0; n < 60 && fb < 0; n++) begin
         @(negedge clk_1x);
         if (!core_reset_b) fb = cyc;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL glitch_early got=%b exp=0", early); end
      total++; if (fb - e2 !== 26) begin bad++; $display("FAIL glitch_lat got=%0d exp=26", fb - e2); end
      total++; if (lock_lost_b !== 1'b0) begin bad++; $display("FAIL glitch_lost_b got=%b exp=0", lock_lost_b); end
   endtask

   task automatic test_saturate;
      for (int i = 0; i < 6; i++) begin
         for (int n = 0; n < 60 && !ready_b; n++) @(negedge clk_1x);
         total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL sat_wait got=%b exp=1", ready_b); end
         pll_locked = 0; @(negedge clk_1x); pll_locked = 1;
         if (i == 5) begin
            // clear lands on the same edge the loss is registered
            @(negedge clk_1x); status_clear = 1;
            @(negedge clk_1x); status_clear = 0;
         end else begin
            repeat (3) @(negedge clk_1x);
         end
         if (i == 4) begin
            total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", cnt_b); end
            total++; if (lock_lost_b !== 1'b1) begin bad++; $display("FAIL sat_lost got=%b exp=1", lock_lost_b); end
         end
      end
      total++; if (cnt_b !== 2'd1) begin bad++; $display("FAIL clr_loss_cnt got=%0d exp=1", cnt_b); end
      total++; if (lock_lost_b !== 1'b1) begin bad++; $display("FAIL clr_loss_lost got=%b exp=1", lock_lost_b); end
   endtask

   task automatic test_user_reset;
      int hi = 0;
      for (int n = 0; n < 60 && !ready_b; n++) @(negedge clk_1x);
      total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL user_wait got=%b exp=1", ready_b); end
      user_reset_req = 1; @(negedge clk_1x); user_reset_req = 0;
      while (core_reset_b && hi < 60) begin hi++; @(negedge clk_1x); end
      total++; if (hi !== 16) begin bad++; $display("FAIL user_hold got=%0d exp=16", hi); end
      total++; if (lock_lost_b !== 1'b1) begin bad++; $display("FAIL user_lost got=%b exp=1", lock_lost_b); end
      total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL user_ready got=%b exp=1", ready_b); end
      hi = 0;
      user_reset_req = 1; @(negedge clk_1x); user_reset_req = 0;
      if (core_reset_b) hi++;
      repeat (4) begin @(negedge clk_1x); if (core_reset_b) hi++; end
      user_reset_req = 1; @(negedge clk_1x); user_reset_req = 0;
      if (core_reset_b) hi++;
      @(negedge clk_1x);
      while (core_reset_b && hi < 80) begin hi++; @(negedge clk_1x); end
      total++; if (hi !== 21) begin bad++; $display("FAIL user_restart got=%0d exp=21", hi); end
   endtask

   task automatic test_random;
      int run = 0;
      for (int n = 0; n < 2500; n++) begin
         bit ea, eb;
         if (run == 0) begin
            pll_locked = ~pll_locked;
            run = pll_locked ? (($urandom_range(0, 5) == 0) ? 60 : int'($urandom_range(1, 40)))
                             : int'($urandom_range(1, 3));
         end
         run--;
         status_clear = ($urandom_range(0, 49) == 0);
         @(negedge clk_1x);
         ea = exp_ready(cyc, LA);
         eb = exp_ready(cyc, LB);
         total++;
         if ({core_reset_a, ready_a, lock_lost_a, cnt_a} !== {~ea, ea, m_lost_a, 8'(m_cnt_a)}) begin
            bad++;
            $display("FAIL rand_a cyc=%0d got=%b exp=%b", cyc, {core_reset_a, ready_a, lock_lost_a, cnt_a},
                     {~ea, ea, m_lost_a, 8'(m_cnt_a)});
         end
         total++;
         if ({core_reset_b, ready_b, lock_lost_b, cnt_b} !== {~eb, eb, m_lost_b, 2'(m_cnt_b)}) begin
            bad++;
            $display("FAIL rand_b cyc=%0d got=%b exp=%b", cyc, {core_reset_b, ready_b, lock_lost_b, cnt_b},
                     {~eb, eb, m_lost_b, 2'(m_cnt_b)});
         end
      end
      status_clear = 0;
   endtask

   task automatic test_reset_midrun;
      int rst_at = -1, fa = -1, fb = -1;
      pll_locked = 1;
      for (int n = 0; n < 2400 && (rst_at < 0 || fa < 0); n++) begin
         bit ea, eb;
         reset_1x = 0;
         if (rst_at < 0 && ready_a && ready_b) begin
            reset_1x = 1; rst_at = cyc + 1;
         end
         @(negedge clk_1x);
         ea = exp_ready(cyc, LA);
         eb = exp_ready(cyc, LB);
         total++;
         if ({core_reset_a, ready_a, lock_lost_a, cnt_a} !== {~ea, ea, m_lost_a, 8'(m_cnt_a)}) begin
            bad++; $display("FAIL mid_a cyc=%0d got=%b exp_ready=%b", cyc, {core_reset_a, ready_a, lock_lost_a, cnt_a}, ea);
         end
         total++;
         if ({core_reset_b, ready_b, lock_lost_b, cnt_b} !== {~eb, eb, m_lost_b, 2'(m_cnt_b)}) begin
            bad++; $display("FAIL mid_b cyc=%0d got=%b exp_ready=%b", cyc, {core_reset_b, ready_b, lock_lost_b, cnt_b}, eb);
         end
         if (cyc == rst_at) begin
            total++;
            if ({core_reset_a, ready_a, lock_lost_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
               bad++; $display("FAIL mid_rst_a got=%b exp=10000000000", {core_reset_a, ready_a, lock_lost_a, cnt_a});
            end
            total++;
            if ({core_reset_b, ready_b, lock_lost_b, cnt_b} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
               bad++; $display("FAIL mid_rst_b got=%b exp=10000", {core_reset_b, ready_b, lock_lost_b, cnt_b});
            end
         end
         if (rst_at > 0 && cyc > rst_at) begin
            if (fa < 0 && !core_reset_a) fa = cyc;
            if (fb < 0 && !core_reset_b) fb = cyc;
         end
      end
      reset_1x = 0;
      total++; if (rst_at < 0 || fa - (rst_at + 1) !== 1042) begin bad++; $display("FAIL mid_relock_a got=%0d exp=1042", fa - (rst_at + 1)); end
      total++; if (rst_at < 0 || fb - (rst_at + 1) !== 26) begin bad++; $display("FAIL mid_relock_b got=%0d exp=26", fb - (rst_at + 1)); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d exp=finish", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_default_latency();
      test_lock_loss();
      test_glitch_filter();
      test_saturate();
      test_user_reset();
      test_random();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
